// File: rtl/sobel_pkg.sv
// Shared defaults, FSM encoding and magnitude constants for the Sobel frame engine.
package sobel_pkg;

    localparam int DEF_WIDTH  = 150;
    localparam int DEF_HEIGHT = 150;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_PIX_W  = 8;

    localparam int MAG_W   = 12;
    localparam int G_W     = MAG_W - 1;
    localparam int MAG_SAT = 255;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        WRITE,
        FIN
    } state_t;

endpackage

// File: rtl/sobel_mag3x3.sv
// Combinational 3x3 Sobel: |Gx|+|Gy| saturated to 8 bits, compared against a threshold.
module sobel_mag3x3
    import sobel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic [8:0][PIX_W-1:0] pix,
    input  logic [7:0]            threshold,
    output logic [7:0]            mag,
    output logic                  edge_bit
);

    logic [G_W-1:0]   gx;
    logic [G_W-1:0]   gy;
    logic [G_W-1:0]   ax;
    logic [G_W-1:0]   ay;
    logic [MAG_W-1:0] sum;

    always_comb begin
        gx = (G_W'(pix[2]) + (G_W'(pix[5]) << 1) + G_W'(pix[8]))
           - (G_W'(pix[0]) + (G_W'(pix[3]) << 1) + G_W'(pix[6]));
        gy = (G_W'(pix[6]) + (G_W'(pix[7]) << 1) + G_W'(pix[8]))
           - (G_W'(pix[0]) + (G_W'(pix[1]) << 1) + G_W'(pix[2]));
        // Gradients never reach -1024, so negation cannot overflow.
        ax  = gx[G_W-1] ? (G_W'(0) - gx) : gx;
        ay  = gy[G_W-1] ? (G_W'(0) - gy) : gy;
        sum = MAG_W'(ax) + MAG_W'(ay);
        mag = (sum > MAG_W'(MAG_SAT)) ? 8'(MAG_SAT) : sum[7:0];
        edge_bit = (mag > threshold);
    end

endmodule

// File: rtl/sobel_frame_engine.sv
// Raster-scans a grayscale frame, computes a thresholded Sobel bit per pixel and
// writes it to the edge buffer; border pixels are written as 0 without reads.
module sobel_frame_engine
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        threshold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              wr_en
);

    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t state, state_nxt;

    logic [ADDR_W-1:0]     row, col, row_base;
    logic [ADDR_W-1:0]     nxt_row, nxt_col, nxt_base;
    logic [ADDR_W-1:0]     win_row, win_addr, rd_hold;
    logic [3:0]            k;
    logic [1:0]            dc;
    logic [8:0][PIX_W-1:0] p;
    logic [7:0]            thr_r;
    logic                  edge_r;
    logic [7:0]            mag;
    logic                  edge_bit;
    logic                  last_pix;

    function automatic logic is_interior(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c);
        return (r != '0) && (r != LAST_R) && (c != '0) && (c != LAST_C);
    endfunction

    sobel_mag3x3 #(.PIX_W(PIX_W)) u_mag (
        .pix       (p),
        .threshold (thr_r),
        .mag       (mag),
        .edge_bit  (edge_bit)
    );

    always_comb begin
        last_pix = (row == LAST_R) && (col == LAST_C);
        nxt_col  = (col == LAST_C) ? '0 : col + ONE;
        nxt_row  = (col == LAST_C) ? row + ONE : row;
        nxt_base = (col == LAST_C) ? row_base + W_A : row_base;
        win_addr = win_row + ADDR_W'(dc);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = is_interior('0, '0) ? FETCH : WRITE;
            FETCH: if (k == 4'd9) state_nxt = CALC;
            CALC:  state_nxt = WRITE;
            WRITE: begin
                if (last_pix)                           state_nxt = FIN;
                else if (is_interior(nxt_row, nxt_col)) state_nxt = FETCH;
                else                                    state_nxt = WRITE;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window row pointer starts at addr(r-1, c-1) and steps +WIDTH every three issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            win_row  <= '0;
            rd_hold  <= '0;
            k        <= '0;
            dc       <= '0;
            p        <= '0;
            thr_r    <= '0;
            edge_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    row      <= '0;
                    col      <= '0;
                    row_base <= '0;
                    win_row  <= '0 - W_A - ONE;
                    k        <= '0;
                    dc       <= '0;
                    thr_r    <= threshold;
                    edge_r   <= 1'b0;
                end
                FETCH: begin
                    k <= k + 4'd1;
                    if (k != 4'd9) begin
                        rd_hold <= win_addr;
                        if (dc == 2'd2) begin
                            dc      <= '0;
                            win_row <= win_row + W_A;
                        end else begin
                            dc <= dc + 2'd1;
                        end
                    end
                    // Data lags the address by one cycle; shift it in so p[0] ends up first.
                    if (k != 4'd0) p <= {rd_data, p[8:1]};
                end
                CALC: edge_r <= edge_bit && (mag != 8'd0);
                WRITE: if (!last_pix) begin
                    row      <= nxt_row;
                    col      <= nxt_col;
                    row_base <= nxt_base;
                    win_row  <= nxt_base + nxt_col - W_A - ONE;
                    k        <= '0;
                    dc       <= '0;
                    edge_r   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (state == FETCH) || (state == CALC) || (state == WRITE);
        done    = (state == FIN);
        wr_en   = (state == WRITE);
        wr_data = (state == WRITE) && edge_r;
        wr_addr = row_base + col;
        rd_addr = ((state == FETCH) && (k != 4'd9)) ? win_addr : rd_hold;
    end

endmodule

// File: tb/tb_sobel_frame_engine.sv
// Directed bench for sobel_frame_engine on a reduced 16x12 frame with a behavioural frame store.
module tb_sobel_frame_engine;

    localparam int W      = 16;
    localparam int H      = 12;
    localparam int AW     = 8;
    localparam int N      = W * H;
    localparam int STEP_C = W / 2;
    localparam int INTER  = (W - 2) * (H - 2);
    localparam int FRAME_CYC = INTER * 12 + (N - INTER);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    threshold;
    logic          busy, done, wr_data, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0]    rd_data;

    logic [7:0] img      [0:N-1];
    logic       edge_mem [0:N-1];

    int checks = 0;
    int errors = 0;
    int wcount = 0, done_cnt = 0, order_err = 0, nbr_err = 0, expect_next = 0;

    sobel_frame_engine #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .threshold (threshold),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= img[rd_addr];

    function automatic bit nbr_ok(input int rd, input int tgt);
        int dr, dcl;
        dr  = rd / W - tgt / W;
        dcl = rd % W - tgt % W;
        return (dr >= -1) && (dr <= 1) && (dcl >= -1) && (dcl <= 1);
    endfunction

    // Write-order / neighbourhood monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            expect_next <= 0;
        end else begin
            if (wr_en) begin
                if (int'(wr_addr) != expect_next || int'(wr_addr) >= N) order_err <= order_err + 1;
                edge_mem[wr_addr] <= wr_data;
                wcount      <= wcount + 1;
                expect_next <= expect_next + 1;
            end else if (busy && !nbr_ok(int'(rd_addr), expect_next)) begin
                nbr_err <= nbr_err + 1;
            end
            if (done) begin
                done_cnt    <= done_cnt + 1;
                expect_next <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 0: uniform 128, 1: vertical step at STEP_C, 2: single 64 at (5,5)
    task automatic load_img(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r*W+c] = 8'd128;
                    1:       img[r*W+c] = (c < STEP_C) ? 8'd0 : 8'd200;
                    default: img[r*W+c] = (r == 5 && c == 5) ? 8'd64 : 8'd0;
                endcase
    endtask

    function automatic logic exp_bit(input int mode, input int thr, input int r, input int c);
        case (mode)
            0: return 1'b0;
            1: return (r > 0) && (r < H-1) && (c == STEP_C-1 || c == STEP_C);
            default: return (thr < 128) && (r >= 4) && (r <= 6) && (c >= 4) && (c <= 6) && !(r == 5 && c == 5);
        endcase
    endfunction

    function automatic int frame_mism(input int mode, input int thr);
        int m = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (edge_mem[r*W+c] !== exp_bit(mode, thr, r, c)) m++;
        return m;
    endfunction

    task automatic run_frame(input logic [7:0] thr, input int restart_at, input logic [7:0] thr2, input string tag);
        int lat, w0, d0, o0, n0;
        w0 = wcount; d0 = done_cnt; o0 = order_err; n0 = nbr_err;
        @(negedge clk); start = 1'b1; threshold = thr;
        @(negedge clk); start = 1'b0; threshold = ~thr;
        chk({tag, "_busy_t1"}, busy, 1);
        chk({tag, "_wr_en_t1"}, wr_en, 1);
        chk({tag, "_wr_addr_t1"}, wr_addr, 0);
        lat = 1;
        while (done !== 1'b1 && lat < 4000) begin
            @(negedge clk);
            lat++;
            if (lat == restart_at) begin
                start = 1'b1; threshold = thr2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_done_latency"}, lat, FRAME_CYC + 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_write_count"}, wcount - w0, N);
        chk({tag, "_write_order"}, order_err - o0, 0);
        chk({tag, "_rd_nbr"}, nbr_err - n0, 0);
    endtask

    initial begin
        int n, d0;
        rst = 1'b1; start = 1'b0; threshold = 8'd0;
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        load_img(0);
        run_frame(8'd0, 0, 8'd0, "uniform");
        chk("uniform_frame", frame_mism(0, 0), 0);

        load_img(1);
        run_frame(8'd100, 0, 8'd0, "step");
        chk("step_frame", frame_mism(1, 100), 0);
        chk("step_sat_edge", edge_mem[3*W+STEP_C-1], 1);

        load_img(2);
        run_frame(8'd127, 0, 8'd0, "dot127");
        chk("dot127_bit_5_6", edge_mem[5*W+6], 1);
        chk("dot127_frame", frame_mism(2, 127), 0);
        run_frame(8'd128, 0, 8'd0, "dot128");
        chk("dot128_bit_5_6", edge_mem[5*W+6], 0);
        chk("dot128_frame", frame_mism(2, 128), 0);

        load_img(1);
        run_frame(8'd100, 300, 8'd255, "restart");
        chk("restart_frame", frame_mism(1, 100), 0);

        // reset in the middle of fetching pixel (5,5)
        @(negedge clk); start = 1'b1; threshold = 8'd100;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(wr_en === 1'b1 && int'(wr_addr) == 5*W+4) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_5_4", n < 3000, 1);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        run_frame(8'd100, 0, 8'd0, "rescan");
        chk("rescan_frame", frame_mism(1, 100), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
